// File: rtl/fetch_r32i.sv
// rtl/fetch_r32i.sv - RV32I instruction fetch: single-outstanding req/ack, instruction FIFO, flush (optional FETCH_ALIGN_CHECK_EN)
module fetch_r32i #(
    parameter int dataW = 32,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [dataW-1:0] ProgAddr,
    input  logic             Flush,
    output logic             PCAdvance,
    output logic             MemReq,
    output logic [dataW-1:0] MemAddr,
    input  logic             MemAck,
    input  logic [dataW-1:0] MemData,
    output logic [dataW-1:0] Instr,
    output logic [dataW-1:0] InstrAddr,
    output logic             InstrValid,
    input  logic             DecodeReady,
    output logic             FetchFault
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, DISCARD, FAULT} state_t;

    state_t           state, state_next;
    logic             req_next;
    logic [dataW-1:0] addr_next;
    logic             push, pop, cand, misaligned, issue;
    logic [CW-1:0]    count, cnt_next;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [dataW-1:0] data_mem [DEPTH];
    logic [dataW-1:0] addr_mem [DEPTH];

    assign push     = MemAck && (state == WAIT_ACK);
    assign pop      = (count != '0) && DecodeReady;
    assign cnt_next = count + CW'(push) - CW'(pop);
    // A new request may go out when idle, or back-to-back on the ack edge, if the FIFO keeps room for it
    assign cand     = !reset && !Flush && (cnt_next < CW'(DEPTH)) && ((state == IDLE) || push);

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_next;
    assign misaligned = (ProgAddr[1:0] != 2'b00);
    assign FetchFault = fault_q;
`else
    assign misaligned = 1'b0;
    assign FetchFault = 1'b0;
`endif

    assign issue      = cand && !misaligned;
    assign PCAdvance  = issue;
    assign InstrValid = (count != '0);
    assign Instr      = data_mem[rd_ptr];
    assign InstrAddr  = addr_mem[rd_ptr];

    // Control state register: FSM state, request handshake and fault flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            MemReq  <= 1'b0;
            MemAddr <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            MemReq  <= req_next;
            MemAddr <= addr_next;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= fault_next;
`endif
        end
    end

    // Next-state logic; Flush overrides everything and an in-flight request is drained via DISCARD
    always_comb begin
        state_next = state;
        req_next   = MemReq;
        addr_next  = MemAddr;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_next = fault_q;
`endif
        if (Flush) begin
`ifdef FETCH_ALIGN_CHECK_EN
            fault_next = 1'b0;
`endif
            case (state)
                WAIT_ACK, DISCARD: begin
                    if (MemAck) begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end else begin
                        state_next = DISCARD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else begin
            case (state)
                IDLE, WAIT_ACK: begin
                    if (state == IDLE || MemAck) begin
                        if (issue) begin
                            state_next = WAIT_ACK;
                            req_next   = 1'b1;
                            addr_next  = ProgAddr;
                        end else if (cand && misaligned) begin
                            state_next = FAULT;
                            req_next   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                            fault_next = 1'b1;
`endif
                        end else begin
                            state_next = IDLE;
                            req_next   = 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (MemAck) begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Instruction FIFO: push on ack in WAIT_ACK, pop when decode takes the head, cleared by Flush
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else if (Flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= MemData;
                addr_mem[wr_ptr] <= MemAddr;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= cnt_next;
        end
    end
endmodule

// File: tb/tb_fetch_r32i.sv
// tb/tb_fetch_r32i.sv - randomized self-checking bench for fetch_r32i against a transaction-level model
module tb_fetch_r32i;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ProgAddr;
    logic        Flush;
    logic        PCAdvance;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemData;
    logic [31:0] Instr;
    logic [31:0] InstrAddr;
    logic        InstrValid;
    logic        DecodeReady;
    logic        FetchFault;

    fetch_r32i #(.dataW(32), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .ProgAddr(ProgAddr), .Flush(Flush),
        .PCAdvance(PCAdvance), .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
        .MemData(MemData), .Instr(Instr), .InstrAddr(InstrAddr), .InstrValid(InstrValid),
        .DecodeReady(DecodeReady), .FetchFault(FetchFault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_out, m_disc, m_fault;
    logic [31:0] m_addr, pc;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_out = 0; m_disc = 0; m_fault = 0; m_addr = 0; pc = 0;
    endtask

    task automatic cycle(input logic fl, input logic ak, input logic dr, input logic [31:0] tgt);
        logic pop_e, push_e, cand_e, mis, adv_e;
        int   cn;
        @(negedge clock);
        Flush       = fl;
        DecodeReady = dr;
        ProgAddr    = pc;
        MemAck      = ak && m_out;
        MemData     = MemAck ? mdata(m_addr) : $urandom;
        #1;
        pop_e  = (q.size() != 0) && dr;
        push_e = MemAck && m_out && !m_disc;
        cn     = q.size() + int'(push_e) - int'(pop_e);
        cand_e = !fl && (cn < DEPTH) && ((!m_out && !m_fault) || push_e);
`ifdef FETCH_ALIGN_CHECK_EN
        mis = (pc[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        adv_e = cand_e && !mis;
        check("pc_advance", 32'(PCAdvance), 32'(adv_e));
        check("mem_req", 32'(MemReq), 32'(m_out));
        check("mem_addr", MemAddr, m_addr);
        check("instr_valid", 32'(InstrValid), 32'(q.size() != 0));
        check("fetch_fault", 32'(FetchFault), 32'(m_fault));
        if (q.size() != 0) begin
            check("instr", Instr, q[0].d);
            check("instr_addr", InstrAddr, q[0].a);
        end
        @(posedge clock);
        if (fl) begin
            q.delete();
            if (m_out) begin
                if (MemAck) begin
                    m_out = 0; m_disc = 0;
                end else begin
                    m_disc = 1;
                end
            end
            m_fault = 0;
            pc = tgt;
        end else begin
            if (pop_e) void'(q.pop_front());
            if (push_e) q.push_back('{a: m_addr, d: mdata(m_addr)});
            if (MemAck) begin
                m_out = 0; m_disc = 0;
            end
            if (cand_e) begin
                if (mis) m_fault = 1;
                else begin
                    m_out = 1; m_addr = pc; pc = pc + 4;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] tgt;
        reset = 1; Flush = 0; MemAck = 0; MemData = 0; DecodeReady = 0; ProgAddr = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        check("rst_pc_advance", 32'(PCAdvance), 0);
        check("rst_mem_req", 32'(MemReq), 0);
        check("rst_instr_valid", 32'(InstrValid), 0);
        check("rst_instr", Instr, 0);
        check("rst_fetch_fault", 32'(FetchFault), 0);
        reset = 0;

        // zero-wait streaming
        repeat (6) cycle(0, 1, 1, 0);
        // decode back-pressure fills the FIFO then stops issuing
        repeat (4) cycle(0, 1, 0, 0);
        #2;
        check("bp_valid", 32'(InstrValid), 1);
        check("bp_req", 32'(MemReq), 0);
        check("bp_advance", 32'(PCAdvance), 0);
        repeat (4) cycle(0, 1, 1, 0);

        // flush during a wait, response discarded
        repeat (2) cycle(0, 1, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 32'h100);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 1, 0);
        #2;
        check("disc_req_low", 32'(MemReq), 0);
        check("disc_empty", 32'(InstrValid), 0);
        cycle(0, 0, 1, 0);
        #2;
        check("flush_target_addr", MemAddr, 32'h100);
        check("flush_target_req", 32'(MemReq), 1);

        // flush coinciding with the ack
        repeat (3) cycle(0, 1, 1, 0);
        cycle(1, 1, 1, 32'h300);
        #2;
        check("flush_ack_empty", 32'(InstrValid), 0);
        check("flush_ack_req", 32'(MemReq), 0);
        repeat (3) cycle(0, 1, 1, 0);

`ifdef FETCH_ALIGN_CHECK_EN
        cycle(1, 1, 1, 32'h102);
        repeat (2) cycle(0, 1, 1, 0);
        #2;
        check("align_fault", 32'(FetchFault), 1);
        check("align_no_req", 32'(MemReq), 0);
        cycle(1, 0, 1, 32'h200);
        cycle(0, 0, 1, 0);
        #2;
        check("align_recover_addr", MemAddr, 32'h200);
        check("align_recover_fault", 32'(FetchFault), 0);
        repeat (2) cycle(0, 1, 1, 0);
`endif

        // reset in the middle of a request
        cycle(1, 1, 1, 32'h40);
        cycle(0, 0, 1, 0);
        #2;
        check("pre_rst_req", 32'(MemReq), 1);
        check("pre_rst_addr", MemAddr, 32'h40);
        reset = 1;
        #1;
        check("mid_rst_req", 32'(MemReq), 0);
        check("mid_rst_addr", MemAddr, 0);
        check("mid_rst_valid", 32'(InstrValid), 0);
        check("mid_rst_advance", 32'(PCAdvance), 0);
        check("mid_rst_instr_addr", InstrAddr, 0);
        model_reset();
        @(posedge clock);
        #2;
        reset = 0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom & 32'h3FF;
`ifndef FETCH_ALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`else
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
`endif
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 3) != 0), tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_r32i.md
# fetch_r32i

Instruction fetch unit for the RV32I core. It consumes the program address driven by the PC block and tells the PC when to advance. It runs a single-outstanding req/ack transaction against instruction memory and buffers returned words in a small FIFO for decode. A taken branch flushes the FIFO and discards any in-flight response.

## Interface
- dataW, 32, address and instruction width
- DEPTH, 2, instruction FIFO entries (power of two, ≥2)

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ProgAddr  in  dataW  current PC output
- Flush  in  1  branch/jump taken this cycle; PC loads the target at the same edge
- PCAdvance  out  dataW→1  combinational; high when ProgAddr is accepted at the next edge (PC increments on it)
- MemReq  out  1  memory request, registered
- MemAddr  out  dataW  request address, registered, stable while MemReq is high
- MemAck  in  1  memory accepted the request; MemData is valid in the same cycle
- MemData  in  dataW  instruction word
- Instr  out  dataW  FIFO head instruction
- InstrAddr  out  dataW  address of Instr
- InstrValid  out  1  FIFO non-empty
- DecodeReady  in  1  decode consumes the head when InstrValid is high
- FetchFault  out  1  misaligned fetch (see Configuration)

## Operation
- States: IDLE, WAIT_ACK, DISCARD, FAULT.
- Definitions:
  - push = MemAck && state==WAIT_ACK
  - pop = InstrValid && DecodeReady
  - cnt_next = count + push − pop
- Issue = !reset && !Flush && cnt_next < DEPTH && (state==IDLE || push).
- PCAdvance = Issue.
- On Issue: MemAddr ← ProgAddr, MemReq ← 1, state → WAIT_ACK.
- WAIT_ACK:
  - MemReq held high and MemAddr held stable until MemAck.
  - On MemAck, {MemAddr, MemData} is pushed.
  - Next state is WAIT_ACK if Issue, otherwise IDLE with MemReq ← 0.
- Flush, with priority over everything:
  - FIFO cleared (count ← 0); pop and push in that cycle are ignored.
  - No Issue that cycle.
  - In WAIT_ACK without MemAck: state → DISCARD, MemReq stays high.
  - In WAIT_ACK with MemAck: data dropped, state → IDLE, MemReq ← 0.
  - Otherwise: state → IDLE.
- DISCARD:
  - MemReq stays high until MemAck.
  - Data is dropped on MemAck, then state → IDLE and MemReq ← 0.
  - No Issue on that edge.
  - Flush while in DISCARD stays in DISCARD.
- FIFO:
  - Head drives Instr and InstrAddr; InstrValid = (count != 0).
  - Overflow cannot occur: Issue requires cnt_next < DEPTH, and only one request is outstanding.
  - Pop on empty is ignored.
- Reset values: state IDLE, count 0, MemReq 0, MemAddr 0, Instr 0, InstrAddr 0, InstrValid 0, FetchFault 0, PCAdvance 0.
- Reset asserted mid-transaction abandons it. Memory must tolerate MemReq dropping.

## Timing
- Address accept: ProgAddr is sampled at edge E where PCAdvance=1. MemReq is high after E.
- Zero-wait memory (MemAck in the cycle after E): instruction pushed at E+1, InstrValid=1 after E+1. Fetch-to-decode latency is 2 edges.
- Sustained throughput: 1 instruction/cycle with zero-wait memory and DecodeReady=1, because back-to-back Issue happens on the ack edge.
- Throughput with N wait cycles: 1 instruction per N+1 cycles.
- After Flush at edge F:
  - First new Issue at F+1 if not in DISCARD.
  - Otherwise first new Issue on the edge after the discarded MemAck, plus one.
- PCAdvance is purely combinational from state, count, MemAck, DecodeReady and Flush. There are no paths from MemData.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - An Issue candidate with ProgAddr[1:0] != 0 is suppressed: PCAdvance=0, no MemReq.
  - FetchFault ← 1 and state → FAULT.
  - FAULT holds FetchFault high and issues nothing; the FIFO still drains.
  - Flush returns the block to IDLE and clears FetchFault.
- FETCH_ALIGN_CHECK_EN undefined:
  - No check; MemAddr carries ProgAddr unchanged.
  - FetchFault is tied 0 and FAULT is unreachable.

## Test plan
- Reset mid-WAIT_ACK (MemReq=1, MemAddr=0x40) -> all outputs 0 immediately, state IDLE, count 0.
- ProgAddr 0x0,0x4,0x8, MemAck always 1, MemData=0x00000013, DecodeReady=1 -> PCAdvance high every cycle; InstrAddr 0x0,0x4,0x8 on consecutive cycles, 2 edges after each accept.
- DecodeReady=0 with zero-wait memory -> exactly 2 instructions buffered, PCAdvance drops to 0, MemReq low. DecodeReady=1 -> one pop per cycle, Issue resumes the same cycle.
- Memory with 3 wait cycles, Flush in the 2nd wait cycle, ProgAddr→0x100 -> FIFO empties, MemReq stays high until MemAck, the 0x8 data is never shown, next MemAddr=0x100.
- Flush in the same cycle as MemAck -> response dropped, InstrValid=0, Issue for the target on the following edge.
- With FETCH_ALIGN_CHECK_EN, ProgAddr=0x102 -> FetchFault=1, no MemReq, PCAdvance=0. Flush with ProgAddr=0x200 -> FetchFault=0, MemAddr=0x200 next.
